instruction_fetch_queue: RTL
============================

// Module: instruction_fetch_queue
// PURPOSE
//  Decoupling FIFO between instruction fetch and decode/dispatch. Captures
//  {pc, instruction, prediction} each cycle fetch is valid, presents the
//  oldest entry to decode via valid/ready, and back-pressures fetch when full.
//  Flush (branch mispredict/exception recovery) empties it in one cycle.
// PARAMETERS
//  DEPTH  8   entries; power of two, >= 2
//  XLEN   32  width of pc / instruction / predicted pc
// PORTS
//  clk_i              in   1     single clock, rising edge
//  reset_i            in   1     asynchronous, active-high reset
//  flush_i            in   1     discard all entries and this cycle's push/pop
//  fetch_valid_i      in   1     fetch presents an instruction this cycle
//  fetch_pc_i         in   XLEN  pc of presented instruction
//  fetch_instr_i      in   XLEN  instruction word
//  fetch_pred_taken_i in   1     predictor said taken
//  fetch_pred_pc_i    in   XLEN  predicted next pc
//  stall_o            out  1     queue full; fetch must hold pc
//  dec_valid_o        out  1     head entry valid for decode
//  dec_ready_i        in   1     decode accepts head this cycle
//  dec_pc_o           out  XLEN  head pc
//  dec_instr_o        out  XLEN  head instruction
//  dec_pred_taken_o   out  1     head prediction
//  dec_pred_pc_o      out  XLEN  head predicted pc
//  count_o            out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
// BEHAVIOUR
//  - Circular buffer; head/tail ptrs carry an extra wrap bit; full when
//    indices equal and wrap bits differ, empty when fully equal.
//  - Reset (async): ptrs=0, count_o=0, stall_o=0, dec_valid_o=0, all dec_*
//    data outputs 0. Entry storage is not reset.
//  - push = fetch_valid_i & ~full & ~flush_i; written at tail on clk edge.
//  - pop  = dec_valid_o & dec_ready_i & ~flush_i; head advances on clk edge.
//  - stall_o = full (registered state only; no path from dec_ready_i). When
//    full, a same-cycle pop does not admit a push; fetch retries next cycle.
//  - Push and pop in the same cycle (not full, not empty): count unchanged.
//  - Latency without bypass: push in cycle N -> visible at dec_* in N+1.
//  - dec_valid_o = ~empty & ~flush_i; dec_* data = head entry when valid,
//    else 0.
//  - flush_i: next state ptrs=0, count=0; overrides push and pop; stall_o
//    drops the cycle after flush.
//  - Pointer wrap at DEPTH-1 -> 0 toggles the wrap bit; count never exceeds
//    DEPTH and never underflows.
//  - Order preserved: entries leave in exact push order.
// CONFIGURATION
//  IFQ_BYPASS_EN defined: when empty and fetch_valid_i & ~flush_i, dec_*
//    show the fetch inputs combinationally (dec_valid_o=1); if dec_ready_i,
//    the instruction is consumed without being written (0-cycle latency);
//    otherwise it is pushed normally.
//  Not defined: every instruction passes through storage; min latency 1.
// STRUCTURE
//  - Shared struct header (structs.svh): typedef struct packed
//    {pc, instr, pred_taken, pred_pc} ifq_entry_t; IFQ_DEPTH default
//    constant.
//  - No sub-module; storage is an ifq_entry_t array inside this block.
// TESTING
//  - Reset mid-traffic with 3 entries held -> next cycle count_o=0,
//    dec_valid_o=0, dec_pc_o=0.
//  - Push pc 0x0,0x4,..,0x1C with dec_ready_i=0 -> count_o=8, stall_o=1;
//    push at pc 0x20 dropped.
//  - Full, dec_ready_i=1 for 8 cycles -> dec_pc_o 0x0..0x1C in order, then
//    dec_valid_o=0.
//  - Simultaneous push/pop at count 3 for 10 cycles -> count_o stays 3;
//    ptrs wrap; order intact.
//  - flush_i with count 5 plus a same-cycle push -> next cycle count_o=0,
//    dec_valid_o=0, pushed pc absent.
//  - IFQ_BYPASS_EN, empty, push pc 0x40 with dec_ready_i=1 -> dec_pc_o=0x40
//    same cycle; count_o stays 0.

Source files
------------

// File: rtl/instruction_fetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_queue_pkg
//   Shared definitions for the instruction fetch queue: default geometry and
//   the packed entry record {pc, instr, pred_taken, pred_pc} at the default
//   XLEN, for use by anything that needs to build or inspect queue entries.
// ---------------------------------------------------------------------------
package instruction_fetch_queue_pkg;

    localparam int IFQ_DEPTH = 8;
    localparam int IFQ_XLEN  = 32;

    typedef struct packed {
        logic [IFQ_XLEN-1:0] pc;
        logic [IFQ_XLEN-1:0] instr;
        logic                pred_taken;
        logic [IFQ_XLEN-1:0] pred_pc;
    } ifq_entry_t;

endpackage

// File: rtl/instruction_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_queue_if
//   Bundles the fetch-side push port, the decode-side valid/ready port, the
//   flush input and the status outputs of the instruction fetch queue.
//   Modports:
//     slave  - the queue itself (consumes fetch/flush/ready, drives dec_*,
//              stall_o, count_o)
//     master - the environment (fetch unit + decode) driving the queue
//   Signal names keep their _i/_o suffix as seen from the queue.
// ---------------------------------------------------------------------------
interface instruction_fetch_queue_if
    import instruction_fetch_queue_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH,
    parameter int XLEN  = IFQ_XLEN
);
    logic                     flush_i;
    logic                     fetch_valid_i;
    logic [XLEN-1:0]          fetch_pc_i;
    logic [XLEN-1:0]          fetch_instr_i;
    logic                     fetch_pred_taken_i;
    logic [XLEN-1:0]          fetch_pred_pc_i;
    logic                     stall_o;
    logic                     dec_valid_o;
    logic                     dec_ready_i;
    logic [XLEN-1:0]          dec_pc_o;
    logic [XLEN-1:0]          dec_instr_o;
    logic                     dec_pred_taken_o;
    logic [XLEN-1:0]          dec_pred_pc_o;
    logic [$clog2(DEPTH):0]   count_o;

    modport slave (
        input  flush_i, fetch_valid_i, fetch_pc_i, fetch_instr_i,
               fetch_pred_taken_i, fetch_pred_pc_i, dec_ready_i,
        output stall_o, dec_valid_o, dec_pc_o, dec_instr_o,
               dec_pred_taken_o, dec_pred_pc_o, count_o
    );

    modport master (
        output flush_i, fetch_valid_i, fetch_pc_i, fetch_instr_i,
               fetch_pred_taken_i, fetch_pred_pc_i, dec_ready_i,
        input  stall_o, dec_valid_o, dec_pc_o, dec_instr_o,
               dec_pred_taken_o, dec_pred_pc_o, count_o
    );
endinterface

// File: rtl/instruction_fetch_queue.sv
// ---------------------------------------------------------------------------
// instruction_fetch_queue
//   Decoupling FIFO between instruction fetch and decode. Each cycle fetch is
//   valid and the queue is not full, {pc, instr, pred_taken, pred_pc} is
//   written at the tail; the oldest entry is presented to decode through a
//   valid/ready handshake. flush_i empties the queue in one cycle.
//
//   Ports:
//     clk_i    - clock, rising edge
//     reset_i  - asynchronous, active-high reset (pointers only)
//     ifq      - instruction_fetch_queue_if.slave: flush, fetch push port,
//                decode pop port, stall_o (= full) and count_o (occupancy)
//
//   Optional feature (macro IFQ_BYPASS_EN): when the queue is empty, a
//   valid fetch is shown to decode combinationally and, if decode accepts
//   it in the same cycle, it is never written into storage.
// ---------------------------------------------------------------------------
module instruction_fetch_queue
    import instruction_fetch_queue_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH,
    parameter int XLEN  = IFQ_XLEN
)(
    input  logic                          clk_i,
    input  logic                          reset_i,
    instruction_fetch_queue_if.slave      ifq
);

    localparam int AW = $clog2(DEPTH);

    typedef logic [AW:0] ptr_t;   // index plus wrap bit

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            pred_taken;
        logic [XLEN-1:0] pred_pc;
    } entry_t;

    ptr_t   head_q, head_d;
    ptr_t   tail_q, tail_d;
    entry_t mem_q [DEPTH];

    logic          full_w;
    logic          empty_w;
    logic          stored_valid_w;
    logic          bypass_w;
    logic          bypass_take_w;
    logic          push_w;
    logic          pop_w;
    logic [DEPTH-1:0] we_w;
    entry_t        wr_entry_w;
    entry_t        head_entry_w;
    entry_t        dec_entry_w;

    assign full_w  = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
    assign empty_w = (head_q == tail_q);

    assign stored_valid_w = ~empty_w & ~ifq.flush_i;

`ifdef IFQ_BYPASS_EN
    assign bypass_w      = empty_w & ifq.fetch_valid_i & ~ifq.flush_i;
    assign bypass_take_w = bypass_w & ifq.dec_ready_i;
`else
    assign bypass_w      = 1'b0;
    assign bypass_take_w = 1'b0;
`endif

    // Full blocks push even when a pop happens this cycle: stall_o must not
    // depend on dec_ready_i, so fetch simply retries next cycle.
    assign push_w = ifq.fetch_valid_i & ~full_w & ~ifq.flush_i & ~bypass_take_w;
    assign pop_w  = stored_valid_w & ifq.dec_ready_i;

    assign wr_entry_w.pc         = ifq.fetch_pc_i;
    assign wr_entry_w.instr      = ifq.fetch_instr_i;
    assign wr_entry_w.pred_taken = ifq.fetch_pred_taken_i;
    assign wr_entry_w.pred_pc    = ifq.fetch_pred_pc_i;

    // Per-slot write enables decoded from the tail index.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
        assign we_w[gi] = push_w && (tail_q[AW-1:0] == AW'(gi));
    end

    // Entry storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (we_w[i]) begin
                mem_q[i] <= wr_entry_w;
            end
        end
    end

    assign head_entry_w = mem_q[head_q[AW-1:0]];

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (ifq.flush_i) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            head_d = head_q + ptr_t'(pop_w);
            tail_d = tail_q + ptr_t'(push_w);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_comb begin
        dec_entry_w = '0;
        if (stored_valid_w) begin
            dec_entry_w = head_entry_w;
        end else if (bypass_w) begin
            dec_entry_w = wr_entry_w;
        end
    end

    assign ifq.dec_valid_o      = stored_valid_w | bypass_w;
    assign ifq.dec_pc_o         = dec_entry_w.pc;
    assign ifq.dec_instr_o      = dec_entry_w.instr;
    assign ifq.dec_pred_taken_o = dec_entry_w.pred_taken;
    assign ifq.dec_pred_pc_o    = dec_entry_w.pred_pc;
    assign ifq.stall_o          = full_w;
    // Wrap bits make the modular difference land exactly in 0..DEPTH.
    assign ifq.count_o          = tail_q - head_q;

endmodule
